// File: rtl/mem_wb_if.sv
// mem_wb_if: MEM-side write bundle in, WB-side write bundle out, for mem_wb_pipe.
interface mem_wb_if #(
  parameter int NLANE  = 2,
  parameter int REG_W  = 32,
  parameter int ADDR_W = 5
);
  logic [NLANE*ADDR_W-1:0] mem_wd, wb_wd;
  logic [NLANE-1:0]        mem_wreg, wb_wreg, mem_whilo, wb_whilo;
  logic [NLANE*REG_W-1:0]  mem_wdata, wb_wdata, mem_hi, wb_hi, mem_lo, wb_lo;
  modport master (
    output mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo,
    input  wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_whilo
  );
  modport slave (
    input  mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo,
    output wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_whilo
  );
endinterface

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: DEPTH-stage MEM->WB register with stall/bubble/flush and youngest-first forwarding lookup.
// Forwarding logic is built only when MEMWB_FWD_EN is defined; otherwise fwd_* outputs are tied to 0.
module mem_wb_pipe #(
  parameter int NLANE  = 2,
  parameter int DEPTH  = 1,
  parameter int REG_W  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_cur,
  input  logic              stall_nxt,
  input  logic              flush,
  mem_wb_if.slave           bus,
  input  logic [ADDR_W-1:0] fwd_raddr,
  output logic              fwd_hit,
  output logic [REG_W-1:0]  fwd_data,
  output logic              fwd_hilo_hit,
  output logic [REG_W-1:0]  fwd_hi,
  output logic [REG_W-1:0]  fwd_lo
);
  logic [NLANE*ADDR_W-1:0] s_wd    [DEPTH];
  logic [NLANE-1:0]        s_wreg  [DEPTH];
  logic [NLANE*REG_W-1:0]  s_wdata [DEPTH];
  logic [NLANE*REG_W-1:0]  s_hi    [DEPTH];
  logic [NLANE*REG_W-1:0]  s_lo    [DEPTH];
  logic [NLANE-1:0]        s_whilo [DEPTH];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      s_wd    <= '{default: '0};
      s_wreg  <= '{default: '0};
      s_wdata <= '{default: '0};
      s_hi    <= '{default: '0};
      s_lo    <= '{default: '0};
      s_whilo <= '{default: '0};
    end else begin
      if (!stall_cur) begin
        s_wd[0]    <= bus.mem_wd;
        s_wreg[0]  <= bus.mem_wreg;
        s_wdata[0] <= bus.mem_wdata;
        s_hi[0]    <= bus.mem_hi;
        s_lo[0]    <= bus.mem_lo;
        s_whilo[0] <= bus.mem_whilo;
      end else if (!stall_nxt) begin
        s_wd[0]    <= '0;
        s_wreg[0]  <= '0;
        s_wdata[0] <= '0;
        s_hi[0]    <= '0;
        s_lo[0]    <= '0;
        s_whilo[0] <= '0;
      end
      // later stages always advance; only stage 0 is a hold point
      for (int k = 1; k < DEPTH; k++) begin
        s_wd[k]    <= s_wd[k-1];
        s_wreg[k]  <= s_wreg[k-1];
        s_wdata[k] <= s_wdata[k-1];
        s_hi[k]    <= s_hi[k-1];
        s_lo[k]    <= s_lo[k-1];
        s_whilo[k] <= s_whilo[k-1];
      end
    end
  end

  assign bus.wb_wd    = s_wd[DEPTH-1];
  assign bus.wb_wreg  = s_wreg[DEPTH-1];
  assign bus.wb_wdata = s_wdata[DEPTH-1];
  assign bus.wb_hi    = s_hi[DEPTH-1];
  assign bus.wb_lo    = s_lo[DEPTH-1];
  assign bus.wb_whilo = s_whilo[DEPTH-1];

`ifdef MEMWB_FWD_EN
  // scan oldest to youngest so the last match (youngest) wins
  always_comb begin
    fwd_hit      = 1'b0;
    fwd_data     = '0;
    fwd_hilo_hit = 1'b0;
    fwd_hi       = '0;
    fwd_lo       = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      for (int l = 0; l < NLANE; l++) begin
        if (s_wreg[k][l] && fwd_raddr != '0 && s_wd[k][l*ADDR_W +: ADDR_W] == fwd_raddr) begin
          fwd_hit  = 1'b1;
          fwd_data = s_wdata[k][l*REG_W +: REG_W];
        end
        if (s_whilo[k][l]) begin
          fwd_hilo_hit = 1'b1;
          fwd_hi       = s_hi[k][l*REG_W +: REG_W];
          fwd_lo       = s_lo[k][l*REG_W +: REG_W];
        end
      end
    end
  end
`else
  logic unused_fwd_raddr;
  assign unused_fwd_raddr = ^fwd_raddr;
  assign fwd_hit      = 1'b0;
  assign fwd_data     = '0;
  assign fwd_hilo_hit = 1'b0;
  assign fwd_hi       = '0;
  assign fwd_lo       = '0;
`endif
endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb_mem_wb_pipe: table-driven check of mem_wb_pipe (NLANE=2, DEPTH=2) plus HI/LO and reset sequences.
module tb_mem_wb_pipe;
`ifdef MEMWB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, stall_cur, stall_nxt, flush;
  logic [4:0] fwd_raddr;
  logic fwd_hit, fwd_hilo_hit;
  logic [31:0] fwd_data, fwd_hi, fwd_lo;
  int checks = 0;
  int errors = 0;

  mem_wb_if #(.NLANE(2), .REG_W(32), .ADDR_W(5)) bus ();

  mem_wb_pipe #(.NLANE(2), .DEPTH(2), .REG_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .stall_cur(stall_cur), .stall_nxt(stall_nxt), .flush(flush),
    .bus(bus), .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .fwd_hilo_hit(fwd_hilo_hit), .fwd_hi(fwd_hi), .fwd_lo(fwd_lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, flush, sc, sn;
    logic [4:0] wd0; logic we0; logic [31:0] d0;
    logic [4:0] wd1; logic we1; logic [31:0] d1;
    logic [4:0] ra;
    logic [1:0] e_we;
    logic [4:0] e_wd0; logic [31:0] e_d0;
    logic [4:0] e_wd1; logic [31:0] e_d1;
    logic e_hit; logic [31:0] e_fd;
  } vec_t;

  vec_t tv [14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_zero();
    bus.mem_wd = '0; bus.mem_wreg = '0; bus.mem_wdata = '0;
    bus.mem_hi = '0; bus.mem_lo = '0; bus.mem_whilo = '0;
  endtask

  task automatic check_wb_zero(input string name);
    check({name, ".wd"}, 64'(bus.wb_wd), 64'h0);
    check({name, ".wreg"}, 64'(bus.wb_wreg), 64'h0);
    check({name, ".wdata"}, bus.wb_wdata, 64'h0);
    check({name, ".hi"}, bus.wb_hi, 64'h0);
    check({name, ".lo"}, bus.wb_lo, 64'h0);
    check({name, ".whilo"}, 64'(bus.wb_whilo), 64'h0);
  endtask

  initial begin
    //        rst flu sc sn  wd0 we0 d0      wd1 we1 d1     ra  e_we   e_wd0 e_d0   e_wd1 e_d1  hit fd
    tv[0]  = '{1, 0, 0, 0,  3, 1, 'h11,    0, 1, 'h55,  3,  2'b00, 0, 0,      0, 0,     0, 0};
    tv[1]  = '{1, 0, 0, 0,  3, 1, 'h11,    0, 1, 'h55,  3,  2'b00, 0, 0,      0, 0,     0, 0};
    tv[2]  = '{0, 0, 0, 0,  3, 1, 'h11,    0, 0, 0,     3,  2'b00, 0, 0,      0, 0,     1, 'h11};
    tv[3]  = '{0, 0, 0, 0,  5, 1, 'h22,    6, 1, 'h33,  3,  2'b01, 3, 'h11,   0, 0,     1, 'h11};
    tv[4]  = '{0, 0, 1, 0,  0, 0, 0,       7, 1, 'h44,  7,  2'b11, 5, 'h22,   6, 'h33,  0, 0};
    tv[5]  = '{0, 0, 0, 0,  0, 0, 0,       0, 0, 0,     7,  2'b00, 0, 0,      0, 0,     0, 0};
    tv[6]  = '{0, 0, 0, 0,  9, 1, 'hAB,    0, 0, 0,     9,  2'b00, 0, 0,      0, 0,     1, 'hAB};
    tv[7]  = '{0, 0, 1, 1,  1, 1, 'hFF,    0, 0, 0,     9,  2'b01, 9, 'hAB,   0, 0,     1, 'hAB};
    tv[8]  = '{0, 0, 1, 1,  1, 1, 'hFF,    0, 0, 0,     9,  2'b01, 9, 'hAB,   0, 0,     1, 'hAB};
    tv[9]  = '{0, 0, 1, 1,  1, 1, 'hFF,    0, 0, 0,     9,  2'b01, 9, 'hAB,   0, 0,     1, 'hAB};
    tv[10] = '{0, 0, 0, 0,  0, 1, 'h77,    4, 1, 3,     0,  2'b01, 9, 'hAB,   0, 0,     0, 0};
    tv[11] = '{0, 0, 0, 0,  4, 1, 1,       4, 1, 2,     4,  2'b11, 0, 'h77,   4, 3,     1, 2};
    tv[12] = '{0, 1, 1, 1,  8, 1, 'h99,    0, 0, 0,     4,  2'b00, 0, 0,      0, 0,     0, 0};
    tv[13] = '{0, 0, 0, 0,  0, 0, 0,       0, 0, 0,     0,  2'b00, 0, 0,      0, 0,     0, 0};

    rst = 1'b1; flush = 1'b0; stall_cur = 1'b0; stall_nxt = 1'b0; fwd_raddr = '0;
    drive_zero();
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      rst = tv[i].rst; flush = tv[i].flush; stall_cur = tv[i].sc; stall_nxt = tv[i].sn;
      bus.mem_wd = {tv[i].wd1, tv[i].wd0};
      bus.mem_wreg = {tv[i].we1, tv[i].we0};
      bus.mem_wdata = {tv[i].d1, tv[i].d0};
      fwd_raddr = tv[i].ra;
      step();
      check($sformatf("v%0d.wreg", i), 64'(bus.wb_wreg), 64'(tv[i].e_we));
      check($sformatf("v%0d.wd", i), 64'(bus.wb_wd), 64'({tv[i].e_wd1, tv[i].e_wd0}));
      check($sformatf("v%0d.wdata", i), bus.wb_wdata, {tv[i].e_d1, tv[i].e_d0});
      check($sformatf("v%0d.fwd_hit", i), 64'(fwd_hit), 64'(FWD & tv[i].e_hit));
      check($sformatf("v%0d.fwd_data", i), 64'(fwd_data), FWD ? 64'(tv[i].e_fd) : 64'h0);
      check($sformatf("v%0d.fwd_hilo_hit", i), 64'(fwd_hilo_hit), 64'h0);
    end
    check_wb_zero("after_table");

    // HI/LO: lane0 write ends in stage 1, younger lane1 write in stage 0
    @(negedge clk);
    drive_zero();
    bus.mem_whilo = 2'b01; bus.mem_hi = {32'h0, 32'h5}; bus.mem_lo = {32'h0, 32'h6};
    step();
    @(negedge clk);
    bus.mem_whilo = 2'b10; bus.mem_hi = {32'h7, 32'h0}; bus.mem_lo = {32'h8, 32'h0};
    step();
    check("hilo1.hit", 64'(fwd_hilo_hit), 64'(FWD));
    check("hilo1.hi", 64'(fwd_hi), FWD ? 64'h7 : 64'h0);
    check("hilo1.lo", 64'(fwd_lo), FWD ? 64'h8 : 64'h0);
    check("hilo1.wb_whilo", 64'(bus.wb_whilo), 64'h1);
    check("hilo1.wb_hi", bus.wb_hi, {32'h0, 32'h5});
    check("hilo1.wb_lo", bus.wb_lo, {32'h0, 32'h6});
    @(negedge clk);
    drive_zero();
    step();
    check("hilo2.hit", 64'(fwd_hilo_hit), 64'(FWD));
    check("hilo2.hi", 64'(fwd_hi), FWD ? 64'h7 : 64'h0);
    check("hilo2.wb_whilo", 64'(bus.wb_whilo), 64'h2);
    check("hilo2.wb_lo", bus.wb_lo, {32'h8, 32'h0});

    // mid-operation reset discards in-flight writes
    @(negedge clk);
    bus.mem_wd = {5'd2, 5'd1}; bus.mem_wreg = 2'b11; bus.mem_wdata = {32'hC, 32'hB};
    bus.mem_whilo = 2'b11; bus.mem_hi = {32'h1, 32'h2}; bus.mem_lo = {32'h3, 32'h4};
    step();
    @(negedge clk);
    rst = 1'b1;
    fwd_raddr = 5'd1;
    step();
    check_wb_zero("rst_mid");
    check("rst_mid.fwd_hit", 64'(fwd_hit), 64'h0);
    check("rst_mid.fwd_hilo_hit", 64'(fwd_hilo_hit), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("rst_mid.wreg_after", 64'(bus.wb_wreg), 64'h0);
    step();
    check("rst_mid.wdata_refill", bus.wb_wdata, {32'hC, 32'hB});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_wb_pipe.md
Name: mem_wb_pipe

Overview:
- Parametrised MEM→WB pipeline register for the multi-issue core: NLANE lanes, DEPTH retiming stages between the MEM output and the register file / HI-LO write ports.
- Each lane carries a register-file write (address, enable, data) and a HI/LO write (hi, lo, enable).
- Supports stall-hold, bubble insertion, synchronous flush and per-stage valid tracking.
- Provides a forwarding lookup that returns the youngest pending write held in any stage, for ID-stage bypass.

Parameters:
- NLANE, 2, number of issue lanes; lane index order = program order, higher index = younger.
- DEPTH, 1, number of register stages (≥1); wb_* outputs come from the last stage.
- REG_W, 32, data width of wdata/hi/lo.
- ADDR_W, 5, register address width.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  reset rst, synchronous, active-high; clock clk.
- stall_cur  in  1  this stage stalled (hold point at stage 0).
- stall_nxt  in  1  next stage stalled.
- flush  in  1  discard all stages (exception/redirect).
- mem_wd  in  NLANE*ADDR_W  per-lane destination register address.
- mem_wreg  in  NLANE  per-lane register write enable.
- mem_wdata  in  NLANE*REG_W  per-lane write data.
- mem_hi  in  NLANE*REG_W  per-lane HI value.
- mem_lo  in  NLANE*REG_W  per-lane LO value.
- mem_whilo  in  NLANE  per-lane HI/LO write enable.
- wb_wd  out  NLANE*ADDR_W  last-stage address.
- wb_wreg  out  NLANE  last-stage write enable.
- wb_wdata  out  NLANE*REG_W  last-stage data.
- wb_hi  out  NLANE*REG_W  last-stage HI.
- wb_lo  out  NLANE*REG_W  last-stage LO.
- wb_whilo  out  NLANE  last-stage HI/LO enable.
- fwd_raddr  in  ADDR_W  forwarding lookup address.
- fwd_hit  out  1  pending register write to fwd_raddr exists.
- fwd_data  out  REG_W  youngest pending data for fwd_raddr.
- fwd_hilo_hit  out  1  pending HI/LO write exists.
- fwd_hi  out  REG_W  youngest pending HI.
- fwd_lo  out  REG_W  youngest pending LO.

Behaviour:
- Reset (rst=1 at posedge): every stage field in every lane is cleared — addresses to 0, enables to 0, data/hi/lo to 0. All wb_* outputs read 0 on the following cycle. Reset mid-operation discards all in-flight writes.
- Priority at each posedge: rst > flush > stall rules > normal advance.
- flush=1: all stages cleared exactly as on reset, regardless of stall inputs.
- Stage 0, stall_cur=1 and stall_nxt=0: load a bubble (all enables 0, addr 0, data 0).
- Stage 0, stall_cur=1 and stall_nxt=1: hold current contents.
- Stage 0, stall_cur=0: capture mem_* for all lanes.
- Stages 1..DEPTH-1: advance every cycle (stage k ← stage k-1). They are never held; only the hold point stalls.
- Latency: mem_* to wb_* is DEPTH cycles when unstalled. DEPTH=1 reproduces the classic single MEM/WB register.
- Lanes are independent; there is no cross-lane masking inside the block. Two lanes writing the same address in one stage are both presented on wb_*; the register file resolves in favour of the higher lane.
- Forwarding (combinational on stage contents, not on mem_* inputs):
  - Search order is youngest first: stage 0, then increasing stage index; within a stage, highest lane first.
  - First entry with wreg=1 and wd==fwd_raddr gives fwd_hit=1 and fwd_data = that wdata.
  - fwd_raddr==0 always gives fwd_hit=0 and fwd_data=0.
  - HI/LO search uses the same order on whilo=1 entries and returns that entry's hi and lo.
  - On a miss, data outputs are 0.
- A held stage-0 entry remains visible to forwarding while held.

Optional Feature:
- Macro MEMWB_FWD_EN.
- Defined: the forwarding logic above is built.
- Undefined: fwd_hit, fwd_data, fwd_hilo_hit, fwd_hi and fwd_lo are tied to 0 and no comparators are synthesised. fwd_raddr is ignored. wb_* behaviour is unchanged.

Test Plan:
- DEPTH=2, NLANE=2; rst=1 two cycles, then lane0 wd=3, wreg=1, wdata=0x11, no stalls → wb lane0 wd=3, wdata=0x11 exactly 2 cycles later; all wb_* are 0 during and right after reset.
- stall_cur=1, stall_nxt=0 with lane1 wd=7, wreg=1 → bubble enters: stage 0 wreg=0, and 0 appears on wb_* DEPTH cycles later.
- stall_cur=1, stall_nxt=1 for 3 cycles with wd=9, wdata=0xAB captured → stage 0 holds; fwd_raddr=9 gives fwd_hit=1, fwd_data=0xAB throughout.
- Stage 0 lane0 wd=4 (0x1), stage 0 lane1 wd=4 (0x2), stage 1 lane1 wd=4 (0x3), fwd_raddr=4 → fwd_data=0x2. fwd_raddr=0 with a wd=0, wreg=1 entry present → fwd_hit=0.
- flush=1 asserted simultaneously with stall_cur=1, stall_nxt=1 and valid entries in all stages → next cycle all enables 0, fwd_hit=0, fwd_hilo_hit=0.
- whilo=1 in lane0 (hi=0x5, lo=0x6) in stage 1 and lane1 (hi=0x7, lo=0x8) in stage 0 → fwd_hilo_hit=1, fwd_hi=0x7, fwd_lo=0x8. With MEMWB_FWD_EN undefined, all fwd outputs are 0.
